// File: rtl/decode_queue.sv
// decode_queue: RV32I instruction pre-decoder feeding a DEPTH-entry FIFO.
// Each accepted word is classified, its immediate sign-extended to XLEN, and
// the decoded result is queued with its PC; the head entry drives out_*.
module decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [8:0]                 out_class,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [4:0]                 out_rd,
    output logic [2:0]                 out_funct3,
    output logic [6:0]                 out_funct7,
    output logic [3:0]                 out_alu_bits,
    output logic signed [XLEN-1:0]     out_imm,
    output logic                       out_rs1_v,
    output logic                       out_rs2_v,
    output logic                       out_rd_v,
    output logic                       out_imm_v,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH):0]     count,
    output logic [CNT_W-1:0]           illegal_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Class bit positions inside the one-hot vector.
    localparam int C_OPIMM  = 0;
    localparam int C_OP     = 1;
    localparam int C_LOAD   = 2;
    localparam int C_STORE  = 3;
    localparam int C_AUIPC  = 4;
    localparam int C_LUI    = 5;
    localparam int C_BRANCH = 6;
    localparam int C_JALR   = 7;
    localparam int C_JAL    = 8;

    // Decode results for the word currently offered on the input.
    logic [8:0]              cls_raw;
    logic [8:0]              dec_cls;
    logic                    dec_illegal;
    logic [3:0]              dec_flags;   // {rs1_v, rs2_v, rd_v, imm_v}
    logic signed [31:0]      imm32;
    logic signed [XLEN-1:0]  dec_imm;

    // Queue storage: payload only, no reset needed (outputs are gated).
    logic [XLEN-1:0]         mem_pc    [DEPTH];
    logic [24:0]             mem_instr [DEPTH];   // instr[31:7]
    logic [8:0]              mem_cls   [DEPTH];
    logic [3:0]              mem_flags [DEPTH];
    logic signed [XLEN-1:0]  mem_imm   [DEPTH];
    logic                    mem_ill   [DEPTH];

    // Control state.
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CNT_W-1:0] illcnt_q, illcnt_d;

    logic push, pop;
    logic [24:0] head_instr;

    assign in_ready  = (count_q < FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign count       = count_q;
    assign illegal_cnt = illcnt_q;

    // Classify the incoming word and build its sign-extended immediate.
    always_comb begin
        cls_raw = '0;
        unique case (in_instr[6:2])
            5'b00000: cls_raw[C_LOAD]   = 1'b1;
            5'b00100: cls_raw[C_OPIMM]  = 1'b1;
            5'b00101: cls_raw[C_AUIPC]  = 1'b1;
            5'b01000: cls_raw[C_STORE]  = 1'b1;
            5'b01100: cls_raw[C_OP]     = 1'b1;
            5'b01101: cls_raw[C_LUI]    = 1'b1;
            5'b11000: cls_raw[C_BRANCH] = 1'b1;
            5'b11001: cls_raw[C_JALR]   = 1'b1;
            5'b11011: cls_raw[C_JAL]    = 1'b1;
            default:  cls_raw = '0;
        endcase
        dec_illegal = (in_instr[1:0] != 2'b11) || (cls_raw == '0);
        dec_cls     = dec_illegal ? 9'd0 : cls_raw;

        dec_flags[3] = dec_cls[C_OP] | dec_cls[C_OPIMM] | dec_cls[C_LOAD] |
                       dec_cls[C_STORE] | dec_cls[C_BRANCH] | dec_cls[C_JALR];
        dec_flags[2] = dec_cls[C_OP] | dec_cls[C_STORE] | dec_cls[C_BRANCH];
        dec_flags[1] = dec_cls[C_OP] | dec_cls[C_OPIMM] | dec_cls[C_LOAD] |
                       dec_cls[C_LUI] | dec_cls[C_AUIPC] | dec_cls[C_JAL] |
                       dec_cls[C_JALR];
        dec_flags[0] = (dec_cls != '0) & ~dec_cls[C_OP];

        imm32 = '0;
        if (dec_cls[C_OPIMM] | dec_cls[C_LOAD] | dec_cls[C_JALR])
            imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        else if (dec_cls[C_STORE])
            imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        else if (dec_cls[C_BRANCH])
            imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
        else if (dec_cls[C_LUI] | dec_cls[C_AUIPC])
            imm32 = {in_instr[31:12], 12'b0};
        else if (dec_cls[C_JAL])
            imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
        // imm32 is signed, so widening to XLEN replicates instr[31].
        dec_imm = XLEN'(imm32);
    end

    // Next-state for pointers, occupancy and the saturating illegal counter.
    always_comb begin
        count_d  = count_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        illcnt_d = illcnt_q;
        if (flush) begin
            count_d = '0;
            wptr_d  = '0;
            rptr_d  = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
        if (push && dec_illegal && (illcnt_q != '1))
            illcnt_d = illcnt_q + 1'b1;
    end

    // Control registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            illcnt_q <= '0;
        end else begin
            count_q  <= count_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            illcnt_q <= illcnt_d;
        end
    end

    // Write the decoded entry into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wptr_q]    <= in_pc;
            mem_instr[wptr_q] <= in_instr[31:7];
            mem_cls[wptr_q]   <= dec_cls;
            mem_flags[wptr_q] <= dec_flags;
            mem_imm[wptr_q]   <= dec_imm;
            mem_ill[wptr_q]   <= dec_illegal;
        end
    end

    // Present the head entry, forced to zero while the queue is empty.
    always_comb begin
        head_instr   = mem_instr[rptr_q];
        out_pc       = '0;
        out_class    = '0;
        out_rs1      = '0;
        out_rs2      = '0;
        out_rd       = '0;
        out_funct3   = '0;
        out_funct7   = '0;
        out_alu_bits = '0;
        out_imm      = '0;
        out_rs1_v    = 1'b0;
        out_rs2_v    = 1'b0;
        out_rd_v     = 1'b0;
        out_imm_v    = 1'b0;
        out_illegal  = 1'b0;
        if (out_valid) begin
            // head_instr[k] holds instr[k+7]
            out_pc       = mem_pc[rptr_q];
            out_class    = mem_cls[rptr_q];
            out_rs1      = head_instr[12:8];
            out_rs2      = head_instr[17:13];
            out_rd       = head_instr[4:0];
            out_funct3   = head_instr[7:5];
            out_funct7   = head_instr[24:18];
            out_alu_bits = {head_instr[23], head_instr[7:5]};
            out_imm      = mem_imm[rptr_q];
            out_rs1_v    = mem_flags[rptr_q][3];
            out_rs2_v    = mem_flags[rptr_q][2];
            out_rd_v     = mem_flags[rptr_q][1];
            out_imm_v    = mem_flags[rptr_q][0];
            out_illegal  = mem_ill[rptr_q];
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed bench for decode_queue (XLEN=32, DEPTH=4, CNT_W=2).
module tb_decode_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [XLEN-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [8:0]        out_class;
    logic [4:0]        out_rs1, out_rs2, out_rd;
    logic [2:0]        out_funct3;
    logic [6:0]        out_funct7;
    logic [3:0]        out_alu_bits;
    logic [XLEN-1:0]   out_imm;
    logic              out_rs1_v, out_rs2_v, out_rd_v, out_imm_v;
    logic              out_illegal;
    logic [$clog2(DEPTH):0] count;
    logic [CNT_W-1:0]  illegal_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_class(out_class), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_alu_bits(out_alu_bits),
        .out_imm(out_imm), .out_rs1_v(out_rs1_v), .out_rs2_v(out_rs2_v),
        .out_rd_v(out_rd_v), .out_imm_v(out_imm_v), .out_illegal(out_illegal),
        .count(count), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        step(); step();
        rst = 1'b0;
        step();
        n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        n_chk++; if (illegal_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_illcnt got %0d exp 0", illegal_cnt); end
        n_chk++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_out_pc got %h exp 0", out_pc); end
    endtask

    task automatic test_addi();
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100;
        step();
        in_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got %b exp 1", out_valid); end
        n_chk++; if (out_class !== 9'h001) begin n_fail++; $display("FAIL addi_class got %h exp 001", out_class); end
        n_chk++; if (out_rd !== 5'd1) begin n_fail++; $display("FAIL addi_rd got %0d exp 1", out_rd); end
        n_chk++; if (out_rs1 !== 5'd0) begin n_fail++; $display("FAIL addi_rs1 got %0d exp 0", out_rs1); end
        n_chk++; if (out_imm !== 32'd5) begin n_fail++; $display("FAIL addi_imm got %h exp 5", out_imm); end
        n_chk++; if ({out_rs1_v, out_rs2_v, out_rd_v, out_imm_v} !== 4'b1011) begin n_fail++; $display("FAIL addi_flags got %b exp 1011", {out_rs1_v, out_rs2_v, out_rd_v, out_imm_v}); end
        n_chk++; if (out_pc !== 32'h100) begin n_fail++; $display("FAIL addi_pc got %h exp 100", out_pc); end
        n_chk++; if (count !== 3'd1) begin n_fail++; $display("FAIL addi_count got %0d exp 1", count); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_pop_valid got %b exp 0", out_valid); end
        n_chk++; if (out_imm !== 32'h0) begin n_fail++; $display("FAIL addi_pop_imm got %h exp 0", out_imm); end
    endtask

    task automatic test_immediates();
        in_valid = 1'b1;
        in_instr = 32'hFFF00113; in_pc = 32'h104; step();
        in_instr = 32'h800000EF; in_pc = 32'h108; step();
        in_instr = 32'hFE000EE3; in_pc = 32'h10C; step();
        in_valid = 1'b0;
        n_chk++; if (count !== 3'd3) begin n_fail++; $display("FAIL imm_count got %0d exp 3", count); end
        n_chk++; if (out_imm !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL imm_I got %h exp FFFFFFFF", out_imm); end
        n_chk++; if (out_rd !== 5'd2) begin n_fail++; $display("FAIL imm_I_rd got %0d exp 2", out_rd); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        n_chk++; if (out_imm !== 32'hFFF00000) begin n_fail++; $display("FAIL imm_J got %h exp FFF00000", out_imm); end
        n_chk++; if (out_class !== 9'h100) begin n_fail++; $display("FAIL imm_J_class got %h exp 100", out_class); end
        n_chk++; if ({out_rs1_v, out_rs2_v, out_rd_v, out_imm_v} !== 4'b0011) begin n_fail++; $display("FAIL imm_J_flags got %b exp 0011", {out_rs1_v, out_rs2_v, out_rd_v, out_imm_v}); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        n_chk++; if (out_imm !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL imm_B got %h exp FFFFFFFC", out_imm); end
        n_chk++; if (out_class !== 9'h040) begin n_fail++; $display("FAIL imm_B_class got %h exp 040", out_class); end
        n_chk++; if ({out_rs1_v, out_rs2_v, out_rd_v, out_imm_v} !== 4'b1101) begin n_fail++; $display("FAIL imm_B_flags got %b exp 1101", {out_rs1_v, out_rs2_v, out_rd_v, out_imm_v}); end
        n_chk++; if (out_funct7 !== 7'h7F || out_alu_bits !== 4'b1000) begin n_fail++; $display("FAIL imm_B_funct got %h/%h exp 7f/8", out_funct7, out_alu_bits); end
        n_chk++; if (out_pc !== 32'h10C) begin n_fail++; $display("FAIL imm_B_pc got %h exp 10c", out_pc); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL imm_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_full();
        logic [31:0] exp_pc;
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093;
        for (int i = 0; i < DEPTH; i++) begin
            in_pc = 32'h200 + 32'(4 * i);
            step();
        end
        n_chk++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d exp 4", count); end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
        in_pc = 32'h2F0; step();
        n_chk++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_ignored got %0d exp 4", count); end
        out_ready = 1'b1; step();
        in_valid = 1'b0; out_ready = 1'b0;
        n_chk++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_poppush got %0d exp 3", count); end
        for (int i = 1; i < DEPTH; i++) begin
            exp_pc = 32'h200 + 32'(4 * i);
            n_chk++; if (out_pc !== exp_pc) begin n_fail++; $display("FAIL full_order%0d got %h exp %h", i, out_pc, exp_pc); end
            out_ready = 1'b1; step(); out_ready = 1'b0;
        end
        in_valid = 1'b1; in_pc = 32'h300; step(); in_valid = 1'b0;
        n_chk++; if (out_pc !== 32'h300 || count !== 3'd1) begin n_fail++; $display("FAIL full_wrap got %h/%0d exp 300/1", out_pc, count); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
    endtask

    task automatic test_illegal();
        in_valid = 1'b1;
        in_instr = 32'h00000000; in_pc = 32'h400; step();
        in_instr = 32'h0000007F; in_pc = 32'h404; step();
        in_valid = 1'b0;
        n_chk++; if (out_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_flag got %b exp 1", out_illegal); end
        n_chk++; if (out_class !== 9'h0) begin n_fail++; $display("FAIL ill_class got %h exp 0", out_class); end
        n_chk++; if (illegal_cnt !== 2'd2) begin n_fail++; $display("FAIL ill_cnt got %0d exp 2", illegal_cnt); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        n_chk++; if (out_illegal !== 1'b1 || out_imm !== 32'h0 || out_imm_v !== 1'b0 || out_rs1_v !== 1'b0) begin n_fail++; $display("FAIL ill_second got ill=%b imm=%h immv=%b rs1v=%b exp 1/0/0/0", out_illegal, out_imm, out_imm_v, out_rs1_v); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00000000;
        step(); step();
        in_valid = 1'b0;
        n_chk++; if (illegal_cnt !== 2'd3) begin n_fail++; $display("FAIL ill_saturate got %0d exp 3", illegal_cnt); end
        out_ready = 1'b1; step(); step(); out_ready = 1'b0;
        n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL ill_drain got %0d exp 0", count); end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_instr = 32'h00500093;
        for (int i = 0; i < 3; i++) begin
            in_pc = 32'h500 + 32'(4 * i);
            step();
        end
        n_chk++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_pre got %0d exp 3", count); end
        flush = 1'b1; out_ready = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count got %0d exp 0", count); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b exp 0", out_valid); end
        n_chk++; if (out_pc !== 32'h0 || out_class !== 9'h0 || out_rd !== 5'd0) begin n_fail++; $display("FAIL flush_payload got %h/%h/%0d exp 0", out_pc, out_class, out_rd); end
        n_chk++; if (illegal_cnt !== 2'd3) begin n_fail++; $display("FAIL flush_illcnt got %0d exp 3", illegal_cnt); end
        in_valid = 1'b1; in_pc = 32'h600; step(); in_valid = 1'b0;
        n_chk++; if (out_pc !== 32'h600 || count !== 3'd1) begin n_fail++; $display("FAIL flush_after got %h/%0d exp 600/1", out_pc, count); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; in_instr = 32'h00500093;
        in_pc = 32'h700; step();
        in_pc = 32'h704; step();
        in_valid = 1'b0;
        n_chk++; if (count !== 3'd2) begin n_fail++; $display("FAIL areset_pre got %0d exp 2", count); end
        #1 rst = 1'b1;
        #1;
        n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL areset_count got %0d exp 0", count); end
        n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_hs got %b/%b exp 0/1", out_valid, in_ready); end
        n_chk++; if (illegal_cnt !== 2'd0) begin n_fail++; $display("FAIL areset_illcnt got %0d exp 0", illegal_cnt); end
        step();
        rst = 1'b0;
        step();
        n_chk++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin n_fail++; $display("FAIL areset_after got %b/%h exp 0/0", out_valid, out_pc); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_immediates();
        test_full();
        test_illegal();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
